// File: rtl/arm_pkg.sv
// Shared flag-register types and condition-code constants for the ARM-style
// pipeline: NZCV layout and the "always" condition.
package arm_pkg;

  localparam logic [3:0] COND_AL = 4'b1110;

  // Bit positions inside an NZCV nibble, same order the condition checker uses
  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/status_register_unit.sv
// Architectural NZCV register with EXE capture, direct-write req/ack port,
// EXE-to-ID forwarding (or stall), sticky overflow and a flag-update counter.
module status_register_unit
  import arm_pkg::*;
#(
  parameter bit         FORWARD_EN = 1'b1,
  parameter int         CNT_W      = 16,
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             exe_valid,
  input  logic             exe_s,
  input  logic [3:0]       exe_nzcv,
  input  logic [3:0]       id_cond,
  input  logic             msr_req,
  input  logic [3:0]       msr_data,
  output logic             msr_ack,
  input  logic             sticky_clr,
  output logic [3:0]       status_out,
  output logic             flag_stall,
  output logic             sticky_v,
  output logic [CNT_W-1:0] upd_count
);

  nzcv_t            nzcv_r;
  logic             msr_ack_r;
  logic             sticky_r;
  logic [CNT_W-1:0] cnt_r;

  logic             exe_hot_s;
  logic             exe_wr_s;
  logic             msr_wr_s;
  logic             wr_any_s;
  nzcv_t            wr_data_s;
  logic             wr_v_s;
  logic [3:0]       status_sel_s;

  assign exe_hot_s = exe_valid & exe_s;
  assign exe_wr_s  = exe_hot_s & ~freeze;
  // EXE owns the register when both want it; the request simply waits.
  assign msr_wr_s  = msr_req & ~freeze & ~exe_wr_s;
  assign wr_any_s  = exe_wr_s | msr_wr_s;

  // Select the value a committed write would store this cycle
  always_comb begin
    wr_data_s = nzcv_r;
    if (exe_wr_s) begin
      wr_data_s = nzcv_t'(exe_nzcv);
    end else if (msr_wr_s) begin
      wr_data_s = nzcv_t'(msr_data);
    end else begin
      wr_data_s = nzcv_r;
    end
  end

  assign wr_v_s = wr_any_s & wr_data_s[V];

  // NZCV architectural register
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv_r <= nzcv_t'(RESET_NZCV);
    end else if (wr_any_s) begin
      nzcv_r <= wr_data_s;
    end else begin
      nzcv_r <= nzcv_r;
    end
  end

  // Direct-write acknowledge: a single pulse after each performed write, never under freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      msr_ack_r <= 1'b0;
    end else begin
      msr_ack_r <= msr_wr_s;
    end
  end

  // Sticky overflow: a V=1 write beats a same-cycle clear; frozen cycles change nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_r <= 1'b0;
    end else if (freeze) begin
      sticky_r <= sticky_r;
    end else if (wr_v_s) begin
      sticky_r <= 1'b1;
    end else if (sticky_clr) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  // Committed-write counter, wraps naturally at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (wr_any_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  generate
    if (FORWARD_EN) begin : g_fwd
      // Bypass the in-flight EXE flags so ID never sees stale values
      always_comb begin
        status_sel_s = nzcv_r;
        if (exe_hot_s) begin
          status_sel_s = exe_nzcv;
        end else begin
          status_sel_s = nzcv_r;
        end
      end
    end else begin : g_nofwd
      assign status_sel_s = nzcv_r;
    end
  endgenerate

  assign status_out = rst ? RESET_NZCV : status_sel_s;
  // Without bypass, any flag-setting EXE op forces ID to wait unless its condition is AL.
  assign flag_stall = ~FORWARD_EN & exe_hot_s & (id_cond != COND_AL) & ~rst;

  assign msr_ack   = msr_ack_r;
  assign sticky_v  = sticky_r;
  assign upd_count = cnt_r;

endmodule
